// File: rtl/paddle_engine_pkg.sv
// Shared types and constants for the paddle engine.
//   state_t    : render FSM encoding (idle, erase old footprint, draw, done pulse)
//   ACCEL_HOLD : consecutive same-direction ticks before the step doubles
package paddle_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int ACCEL_HOLD = 8;

endpackage

// File: rtl/paddle_engine_rect_sweep.sv
// Row-major pixel sweep over a PLAT_W x PLAT_H rectangle, shared by the erase
// and draw phases of the paddle renderer.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   load        : restart at col 0 / row 0 (wins over inc)
//   inc         : advance one pixel; col is the inner index
//   col, row    : current offsets inside the rectangle
//   last        : current pixel is the final one of the rectangle
module paddle_engine_rect_sweep #(
    parameter int XW     = 10,
    parameter int PLAT_W = 16,
    parameter int PLAT_H = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          inc,
    output logic [XW-1:0] col,
    output logic [XW-1:0] row,
    output logic          last
);

    localparam logic [XW-1:0] COL_MAX = XW'(PLAT_W - 1);
    localparam logic [XW-1:0] ROW_MAX = XW'(PLAT_H - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_engine.sv
// Player paddle: position register with clamped movement, plus a renderer
// that writes a PLAT_W x PLAT_H rectangle into the framebuffer one pixel per
// cycle, erasing the previously drawn footprint first if the paddle moved.
// Optional build macro PADDLE_ACCEL_EN doubles the step after ACCEL_HOLD
// consecutive same-direction ticks.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   left, right, enable  : movement request, sampled on the enable tick
//   draw                 : render request, accepted only when idle
//   x, y, colour, writeEn: framebuffer pixel write
//   busy, done           : render in progress / one-cycle completion pulse
//   pos_x                : current paddle left edge
module paddle_engine
    import paddle_engine_pkg::*;
#(
    parameter int          XW        = 10,
    parameter int          SCREEN_W  = 160,
    parameter int          PLAT_W    = 16,
    parameter int          PLAT_H    = 2,
    parameter int          PLAT_Y    = 110,
    parameter int          X0        = 32,
    parameter int          SPEED     = 1,
    parameter logic [2:0]  COLOUR    = 3'b100,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          left,
    input  logic          right,
    input  logic          enable,
    input  logic          draw,
    output logic [XW-1:0] x,
    output logic [XW-1:0] y,
    output logic [2:0]    colour,
    output logic          writeEn,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] pos_x
);

    localparam logic [XW:0]   MAX_X  = (XW+1)'(SCREEN_W - PLAT_W);
    localparam logic [XW-1:0] STEP1  = XW'(SPEED);
    localparam logic [XW-1:0] Y_TOP  = XW'(PLAT_Y);

    // ---------------- movement ----------------
    logic          mv_left, mv_right;
    logic [XW-1:0] step;

    assign mv_left  = enable & left & ~right;
    assign mv_right = enable & right & ~left;

`ifdef PADDLE_ACCEL_EN
    localparam logic [XW-1:0] STEP2 = XW'(2 * SPEED);
    logic [3:0] hold_cnt;
    logic       last_right;

    // Doubling only applies while the run continues in the same direction;
    // the first tick after a reversal is always a single step.
    assign step = (hold_cnt >= 4'(ACCEL_HOLD) && last_right == right) ? STEP2 : STEP1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_cnt   <= '0;
            last_right <= 1'b0;
        end else if (enable) begin
            if (mv_left || mv_right) begin
                // a reversal starts a fresh run that already includes this tick
                if (hold_cnt == '0 || last_right != right)
                    hold_cnt <= 4'd1;
                else if (hold_cnt != 4'(ACCEL_HOLD))
                    hold_cnt <= hold_cnt + 4'd1;
                last_right <= right;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign step = STEP1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos_x <= XW'(X0);
        end else if (mv_left) begin
            pos_x <= (pos_x < step) ? '0 : pos_x - step;
        end else if (mv_right) begin
            // compare one bit wider so a step past the top cannot wrap
            if ((XW+1)'(pos_x) + (XW+1)'(step) > MAX_X)
                pos_x <= MAX_X[XW-1:0];
            else
                pos_x <= pos_x + step;
        end
    end

    // ---------------- render FSM ----------------
    state_t        state, state_next;
    logic [XW-1:0] snap_x, drawn_x, base_x;
    logic          drawn_valid;
    logic          sw_load, sw_inc, sw_last;
    logic [XW-1:0] col, row;

    paddle_engine_rect_sweep #(
        .XW     (XW),
        .PLAT_W (PLAT_W),
        .PLAT_H (PLAT_H)
    ) u_sweep (
        .clk    (clk),
        .resetn (resetn),
        .load   (sw_load),
        .inc    (sw_inc),
        .col    (col),
        .row    (row),
        .last   (sw_last)
    );

    always_comb begin
        state_next = state;
        sw_load    = 1'b0;
        sw_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (draw) begin
                    sw_load    = 1'b1;
                    state_next = (drawn_valid && drawn_x != pos_x) ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                sw_inc = 1'b1;
                if (sw_last) begin
                    sw_load    = 1'b1;
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                sw_inc = 1'b1;
                if (sw_last) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            snap_x      <= '0;
            drawn_x     <= '0;
            drawn_valid <= 1'b0;
        end else begin
            state <= state_next;
            // later movement must not shift a render already in flight
            if (state == S_IDLE && draw) snap_x <= pos_x;
            if (state == S_DRAW && sw_last) begin
                drawn_x     <= snap_x;
                drawn_valid <= 1'b1;
            end
        end
    end

    assign base_x  = (state == S_ERASE) ? drawn_x : snap_x;
    assign writeEn = (state == S_ERASE) || (state == S_DRAW);
    assign x       = writeEn ? base_x + col : '0;
    assign y       = writeEn ? Y_TOP + row : '0;
    assign colour  = (state == S_DRAW) ? COLOUR : BG_COLOUR;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_paddle_engine.sv
module tb_paddle_engine;

    localparam int XW = 10;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          left = 1'b0, right = 1'b0, enable = 1'b0, draw = 1'b0;
    logic [XW-1:0] x, y, pos_x, fx, fy, fpos;
    logic [2:0]    colour, fcol;
    logic          writeEn, busy, done, fwe, fbusy, fdone;

    always #5 clk = ~clk;

    paddle_engine dut (
        .clk(clk), .resetn(resetn), .left(left), .right(right), .enable(enable),
        .draw(draw), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done), .pos_x(pos_x)
    );

    // second instance with a larger step, used only for movement saturation
    paddle_engine #(.SPEED(3)) fast (
        .clk(clk), .resetn(resetn), .left(left), .right(right), .enable(enable),
        .draw(1'b0), .x(fx), .y(fy), .colour(fcol), .writeEn(fwe),
        .busy(fbusy), .done(fdone), .pos_x(fpos)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0, done_cnt = 0;
    logic [22:0] exp_q[$];
    logic [22:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // scoreboard: every framebuffer write must match the head of the queue
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            if (writeEn === 1'b1) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_pixel", {9'd0, x, y, colour}, {9'd0, mon_e});
                end
            end
        end
    end

    task automatic push_rect(input int bx, input logic [2:0] c);
        for (int r = 0; r < 2; r++)
            for (int cl = 0; cl < 16; cl++)
                exp_q.push_back({10'(bx + cl), 10'(110 + r), c});
    endtask

    task automatic tick(input logic l, input logic r, input int n);
        repeat (n) begin
            left = l; right = r; enable = 1'b1;
            @(posedge clk); #1;
        end
        enable = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic do_draw(input bit er, input int old_x, input int new_x, input bit extra);
        int n, lat, dc;
        bit got;
        if (er) push_rect(old_x, 3'b000);
        push_rect(new_x, 3'b100);
        lat = er ? 65 : 33;
        dc = done_cnt;
        draw = 1'b1; n = cyc;
        @(posedge clk); #1;
        draw = 1'b0;
        if (extra) begin
            repeat (5) @(posedge clk);
            #1 draw = 1'b1;
            @(posedge clk); #1;
            draw = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", 32'(cyc - n), 32'(lat));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("single_done", 32'(done_cnt - dc), 32'd1);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_pos_x", 32'(pos_x), 32'd32);
        check("rst_writeEn", 32'(writeEn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xy", {12'd0, x, y}, 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // first draw: nothing drawn yet so no erase
        do_draw(1'b0, 0, 32, 1'b0);
        check("t1_pos_x", 32'(pos_x), 32'd32);

        // move left 3, redraw with erase of the old footprint
        tick(1'b1, 1'b0, 3);
        check("t2_pos_x", 32'(pos_x), 32'd29);
        do_draw(1'b1, 32, 29, 1'b0);

        // right bound is SCREEN_W-PLAT_W = 144, left bound 0
        tick(1'b0, 1'b1, 120);
        check("t3_right_clamp", 32'(pos_x), 32'd144);
        tick(1'b0, 1'b1, 1);
        check("t3_right_hold", 32'(pos_x), 32'd144);
        tick(1'b1, 1'b0, 150);
        check("t3_left_clamp", 32'(pos_x), 32'd0);
        tick(1'b1, 1'b0, 1);
        check("t3_left_hold", 32'(pos_x), 32'd0);

        // both held: no motion; draw pulse while busy is ignored
        tick(1'b1, 1'b1, 2);
        check("t4_both_held", 32'(pos_x), 32'd0);
        do_draw(1'b1, 29, 0, 1'b1);

        // reset in the middle of the draw phase
        tick(1'b0, 1'b1, 5);
        check("t5_pos_x", 32'(pos_x), 32'd5);
        push_rect(0, 3'b000);
        push_rect(5, 3'b100);
        draw = 1'b1;
        @(posedge clk); #1;
        draw = 1'b0;
        repeat (40) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_writeEn", 32'(writeEn), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_pos_x", 32'(pos_x), 32'd32);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_fast_rst", 32'(fpos), 32'd32);
        exp_q.delete();
        resetn = 1'b1;
        do_draw(1'b0, 0, 32, 1'b0);

        // sustained movement (acceleration depends on build)
        tick(1'b0, 1'b1, 10);
`ifdef PADDLE_ACCEL_EN
        check("t6_right10", 32'(pos_x), 32'd44);
        check("t6_fast_right10", 32'(fpos), 32'd68);
        tick(1'b1, 1'b0, 20);
        check("t6_left20", 32'(pos_x), 32'd12);
        check("t6_fast_left20", 32'(fpos), 32'd0);
        tick(1'b1, 1'b0, 1);
        check("t6_left21", 32'(pos_x), 32'd10);
        check("t6_fast_left21", 32'(fpos), 32'd0);
`else
        check("t6_right10", 32'(pos_x), 32'd42);
        check("t6_fast_right10", 32'(fpos), 32'd62);
        tick(1'b1, 1'b0, 20);
        check("t6_left20", 32'(pos_x), 32'd22);
        check("t6_fast_left20", 32'(fpos), 32'd2);
        tick(1'b1, 1'b0, 1);
        check("t6_left21", 32'(pos_x), 32'd21);
        check("t6_fast_overshoot", 32'(fpos), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
